// File: rtl/instruction_cache.sv
// Read-only instruction cache: 8 direct-mapped blocks of 4 words, combinational hit path,
// single outstanding block fill from instruction memory.
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic {ST_IDLE, ST_MEM_READ} state_t;

  state_t       state;
  logic [7:0]   valid;
  logic [2:0]   tags [8];
  logic [127:0] data [8];

  logic [2:0] tag;
  logic [2:0] index;
  logic [1:0] offset;
  logic       hit;
  logic       fill_done;
  logic       unused_pc;

  assign tag       = PC[9:7];
  assign index     = PC[6:4];
  assign offset    = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  assign hit       = (state == ST_IDLE) && valid[index] && (tags[index] == tag);
  assign fill_done = (state == ST_MEM_READ) && !MEM_BUSYWAIT;

  assign BUSYWAIT  = ~hit;
  assign MEM_READ  = (state == ST_MEM_READ);

  always_comb begin
    INSTRUCTION = '0;
    if (hit) INSTRUCTION = data[index][{offset, 5'b0} +: 32];
  end

  // MEM_ADDRESS doubles as the fill target, so it must stay frozen for the whole fill.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      valid       <= '0;
      MEM_ADDRESS <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!hit) begin
            MEM_ADDRESS <= {tag, index};
            state       <= ST_MEM_READ;
          end
        end
        ST_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            valid[MEM_ADDRESS[2:0]] <= 1'b1;
            state                   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; a fill can only complete while the FSM is out of reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[MEM_ADDRESS[2:0]] <= MEM_ADDRESS[5:3];
      data[MEM_ADDRESS[2:0]] <= MEM_READDATA;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a behavioural memory and a valid/tag reference model.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 5;
  int          mem_cnt = 0;
  int          rd;
  bit          addr_ok;
  logic        mv [8];
  logic [2:0]  mt [8];
  logic [31:0] exp_q [$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] word(input logic [5:0] a, input logic [1:0] k);
    return {8'hA5, 2'b00, a, 14'h0, k};
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] pc);
    return word({pc[9:7], pc[6:4]}, pc[3:2]);
  endfunction

  // Memory: asserts readiness in the mem_lat-th cycle of a request.
  initial begin
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (MEM_READ === 1'b1) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          MEM_BUSYWAIT = 1'b0;
          MEM_READDATA = {word(MEM_ADDRESS, 2'd3), word(MEM_ADDRESS, 2'd2),
                          word(MEM_ADDRESS, 2'd1), word(MEM_ADDRESS, 2'd0)};
        end
      end else begin
        mem_cnt      = 0;
        MEM_BUSYWAIT = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in the cycle where pc is first presented with the FSM idle.
  task automatic observe(input logic [31:0] pc);
    logic [2:0]  t;
    logic [2:0]  i;
    logic        miss;
    logic [31:0] exp;
    int          nrd;
    bit          aok;
    t    = pc[9:7];
    i    = pc[6:4];
    miss = !(mv[i] && (mt[i] == t));
    exp  = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check("busy_first", 128'(BUSYWAIT), 128'(miss));
    check("mread_first", 128'(MEM_READ), 128'(0));
    if (miss) begin
      nrd = 0;
      aok = 1'b1;
      for (int n = 0; n < 100 && BUSYWAIT !== 1'b0; n++) begin
        @(negedge CLK);
        if (MEM_READ === 1'b1) begin
          nrd++;
          if (MEM_ADDRESS !== {t, i}) aok = 1'b0;
        end
      end
      check("fill_cycles", 128'(nrd), 128'(mem_lat));
      check("fill_addr", 128'(aok), 128'(1));
      check("busy_after_fill", 128'(BUSYWAIT), 128'(0));
      check("mread_after_fill", 128'(MEM_READ), 128'(0));
      mv[i] = 1'b1;
      mt[i] = t;
    end
    check("instr", 128'(INSTRUCTION), 128'(exp));
  endtask

  task automatic fetch(input logic [31:0] pc);
    PC = pc;
    exp_q.push_back(memword(pc));
    @(negedge CLK);
    observe(pc);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      mv[k] = 1'b0;
      mt[k] = '0;
    end
    RESET = 1'b0;
    PC    = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 128'(BUSYWAIT), 128'(1));
    check("rst_instr", 128'(INSTRUCTION), 128'(0));
    check("rst_mread", 128'(MEM_READ), 128'(0));
    check("rst_maddr", 128'(MEM_ADDRESS), 128'(0));
    @(posedge CLK);
    #2;
    RESET = 1'b1;

    // Cold miss, then hits across the rest of block 0.
    mem_lat = 5;
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    fetch(32'h0000_000C);

    // Conflict eviction on index 1 with single-cycle memory.
    mem_lat = 1;
    fetch(32'h0000_0010);
    fetch(32'h0000_0090);
    fetch(32'h0000_0010);
    fetch(32'hFFFF_FC02);
    mem_lat = 2;
    fetch(32'h0000_03FC);
    fetch(32'h0000_03F0);

    // PC change while a fill is outstanding.
    mem_lat = 3;
    PC = 32'h0000_0020;
    @(negedge CLK);
    check("mid_busy", 128'(BUSYWAIT), 128'(1));
    @(posedge CLK);
    #2;
    PC = 32'h0000_0030;
    exp_q.push_back(memword(32'h0000_0030));
    rd      = 0;
    addr_ok = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (MEM_READ !== 1'b1) break;
      rd++;
      if (MEM_ADDRESS !== 6'h02) addr_ok = 1'b0;
    end
    check("mid_fill_cycles", 128'(rd), 128'(3));
    check("mid_fill_addr", 128'(addr_ok), 128'(1));
    mv[2] = 1'b1;
    mt[2] = 3'd0;
    observe(32'h0000_0030);
    @(posedge CLK);
    #2;
    fetch(32'h0000_0020);
    fetch(32'h0000_0034);

    // Reset during a fill.
    mem_lat = 4;
    PC = 32'h0000_0050;
    @(negedge CLK);
    check("abort_busy", 128'(BUSYWAIT), 128'(1));
    @(posedge CLK);
    #2;
    check("abort_pre_mread", 128'(MEM_READ), 128'(1));
    #3;
    RESET = 1'b0;
    #1;
    check("abort_mread", 128'(MEM_READ), 128'(0));
    check("abort_busy_rst", 128'(BUSYWAIT), 128'(1));
    check("abort_instr", 128'(INSTRUCTION), 128'(0));
    check("abort_maddr", 128'(MEM_ADDRESS), 128'(0));
    for (int k = 0; k < 8; k++) mv[k] = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    fetch(32'h0000_0050);
    fetch(32'h0000_0000);
    fetch(32'h0000_0058);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 direct-mapped blocks × 16 bytes (4 instruction words each).
REQ-002 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-low; 0 = in reset.
REQ-004 PC  input  32  byte address of the instruction to fetch, from the PC register; only PC[9:2] are used.
REQ-005 INSTRUCTION  output  32  fetched instruction word; valid only while BUSYWAIT=0.
REQ-006 BUSYWAIT  output  1  stall to the processor; 1 = INSTRUCTION not yet valid, PC must be held.
REQ-007 MEM_READ  output  1  read request to instruction memory.
REQ-008 MEM_ADDRESS  output  6  block address to memory, equal to {tag, index}.
REQ-009 MEM_READDATA  input  128  returned block; bits [32k+31:32k] hold word offset k.
REQ-010 MEM_BUSYWAIT  input  1  memory busy; 0 while MEM_READ=1 means MEM_READDATA is valid this cycle.

Function
REQ-011 The address split SHALL be: tag = PC[9:7], index = PC[6:4], word offset = PC[3:2]; PC[1:0] and PC[31:10] SHALL be ignored.
REQ-012 Each block SHALL hold a valid bit, a 3-bit tag and 128 data bits; only the valid bits are reset.
REQ-013 Hit SHALL be combinational: valid[index] = 1 and stored tag = PC tag, while the FSM is in IDLE.
REQ-014 On a hit, INSTRUCTION SHALL equal the stored word selected by the word offset in the same cycle (0-cycle latency); otherwise INSTRUCTION SHALL be 32'h0.
REQ-015 BUSYWAIT SHALL be 1 whenever there is no hit, including every cycle in MEM_READ.
REQ-016 The FSM SHALL have two states: IDLE and MEM_READ.
REQ-017 IDLE: on a miss at a rising edge, the block SHALL latch {tag, index} into MEM_ADDRESS and the index/tag fill target, then enter MEM_READ; on a hit it SHALL stay in IDLE.
REQ-018 MEM_READ: MEM_READ SHALL be 1 and MEM_ADDRESS SHALL be held constant; the FSM SHALL stay while MEM_BUSYWAIT=1.
REQ-019 MEM_READ with MEM_BUSYWAIT=0 at a rising edge: the block SHALL write MEM_READDATA, the latched tag and valid=1 into the latched index, and return to IDLE.
REQ-020 In IDLE, MEM_READ SHALL be 0 and MEM_ADDRESS SHALL hold its last latched value.
REQ-021 Miss timing SHALL be: miss seen in cycle t; MEM_READ asserted in cycles t+1 through t+N (N ≥ 1 memory cycles); BUSYWAIT low with correct INSTRUCTION in cycle t+N+1 if PC is unchanged.
REQ-022 If PC changes during MEM_READ, the fill SHALL complete for the latched address, after which the new PC is evaluated in IDLE (hit or new miss).
REQ-023 A fill SHALL overwrite the indexed block unconditionally; no write-back, since the cache is read-only.
REQ-024 There SHALL be no back-to-back fill without an intervening IDLE cycle.

Reset
REQ-025 While RESET=0, asynchronously: FSM in IDLE, all 8 valid bits 0, MEM_READ=0, MEM_ADDRESS=6'h00.
REQ-026 Consequently, while RESET=0: BUSYWAIT=1 and INSTRUCTION=32'h0.
REQ-027 Reset asserted during MEM_READ SHALL abort the fill immediately: MEM_READ drops without waiting for an edge, and no block is written or validated.
REQ-028 Data and tag arrays need not be reset; the block SHALL never output them while the matching valid bit is 0.

Verification
REQ-029 Cold miss: release reset, PC=32'h0000_0000, memory returns block 0 = {W3,W2,W1,W0} after 5 cycles -> MEM_READ=1 with MEM_ADDRESS=6'h00 for 5 cycles, then BUSYWAIT=0 and INSTRUCTION=W0.
REQ-030 Hit sweep: after REQ-029, PC=4, 8, 12 in consecutive cycles -> BUSYWAIT=0 every cycle, INSTRUCTION=W1, W2, W3, MEM_READ stays 0.
REQ-031 Conflict eviction: fill PC=32'h010, then PC=32'h090 (same index 1, tag 1) -> miss with MEM_ADDRESS=6'h09; afterwards PC=32'h010 misses again with MEM_ADDRESS=6'h01.
REQ-032 PC change mid-fill: miss on PC=32'h020, change PC to 32'h030 while MEM_BUSYWAIT=1 -> block 2 is filled, then a new miss with MEM_ADDRESS=6'h03; a later PC=32'h020 hits.
REQ-033 Reset mid-fill: assert RESET=0 during MEM_READ -> MEM_READ=0 within the same cycle; after release, the same PC misses again.
REQ-034 Ignored bits: PC=32'hFFFF_FC02 after filling block 0 -> hit returning W0.
